// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream.
// Even rows fold horizontal pair maxima into a half-width line buffer; odd rows emit.
module maxpool2x2 #(
  parameter int BITWIDTH = 8,
  parameter int ROWS     = 480,
  parameter int COLS     = 640
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_valid,
  input  logic [BITWIDTH-1:0] din,
  output logic [BITWIDTH-1:0] dout,
  output logic                dout_valid,
  output logic                frame_done
);

  localparam int CW  = (COLS > 2) ? $clog2(COLS)     : 1;
  localparam int RW  = (ROWS > 2) ? $clog2(ROWS)     : 1;
  localparam int HCW = (COLS > 2) ? $clog2(COLS / 2) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [0:0]          state;
  logic [BITWIDTH-1:0] h_reg;
  logic [BITWIDTH-1:0] pair_max;
  logic [BITWIDTH-1:0] lb_rd;
  logic [HCW-1:0]      lb_idx;
  logic                col_last, row_last, odd_col, emit;

  logic [BITWIDTH-1:0] linebuf [COLS/2];

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign odd_col  = col[0];
  assign lb_idx   = HCW'(col >> 1);
  assign pair_max = (din > h_reg) ? din : h_reg;
  assign lb_rd    = linebuf[lb_idx];
  assign emit     = din_valid && odd_col && (state == EMIT);

  // Raster position and row phase; phase flips on every row wrap, including frame wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      state <= FILL;
    end else if (din_valid) begin
      if (col_last) begin
        col   <= '0;
        row   <= row_last ? '0 : row + RW'(1);
        state <= (state == FILL) ? EMIT : FILL;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       h_reg <= '0;
    else if (din_valid && !odd_col) h_reg <= din;
  end

  // FILL and EMIT never overlap, so one index is never read and written together.
  always_ff @(posedge clk) begin
    if (din_valid && odd_col && (state == FILL))
      linebuf[lb_idx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= emit;
      frame_done <= emit && col_last && row_last;
      if (emit) dout <= (lb_rd > pair_max) ? lb_rd : pair_max;
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Randomized self-checking bench for maxpool2x2 on a 4x4 frame; expectations come
// from a frame array and the window-max rule.
module tb_maxpool2x2;

  localparam int BW = 8;
  localparam int R  = 4;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic [BW-1:0] din = '0;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int n_out       = 0;
  int n_fd        = 0;
  int last_dout   = 0;
  int fr [R][C];

  maxpool2x2 #(.BITWIDTH(BW), .ROWS(R), .COLS(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int win_max(input int r, input int c);
    int m;
    m = fr[r-1][c-1];
    if (fr[r-1][c] > m) m = fr[r-1][c];
    if (fr[r][c-1] > m) m = fr[r][c-1];
    if (fr[r][c]   > m) m = fr[r][c];
    return m;
  endfunction

  // One clock: apply inputs, let the edge pass, check the registered outputs.
  task automatic step(input logic v, input int d, input logic ev, input int ed, input logic efd);
    din_valid = v;
    din       = BW'(d);
    @(posedge clk);
    #1;
    chk("dout_valid", int'(dout_valid), int'(ev));
    chk("frame_done", int'(frame_done), int'(efd));
    if (ev) last_dout = ed;
    chk("dout", int'(dout), last_dout);
    if (dout_valid) n_out++;
    if (frame_done) n_fd++;
  endtask

  // Streams the first npix pixels of fr, with 0..gap_max idle cycles before each.
  task automatic send_frame(input int gap_max, input int npix);
    int   k;
    logic ev;
    k = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (k < npix) begin
          repeat ($urandom_range(gap_max, 0)) step(1'b0, int'($urandom_range(255, 0)), 1'b0, 0, 1'b0);
          ev = (r % 2 == 1) && (c % 2 == 1);
          step(1'b1, fr[r][c], ev, ev ? win_max(r, c) : 0, ev && (r == R-1) && (c == C-1));
        end
        k++;
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) fr[r][c] = r * C + c;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) fr[r][c] = v;
  endtask

  task automatic outputs_cleared(input string tag);
    chk({tag, "_dout"},       int'(dout),       0);
    chk({tag, "_dout_valid"}, int'(dout_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    // Reset held with input activity: nothing may come out.
    for (int i = 0; i < 5; i++) begin
      din_valid = (i % 2 == 0);
      din       = BW'($urandom_range(255, 0));
      @(posedge clk);
      #1;
      outputs_cleared("reset");
    end
    rst = 1'b1;

    // Ramp, back to back.
    fill_ramp();
    n_out = 0; n_fd = 0;
    send_frame(0, R * C);
    chk("ramp_outputs", n_out, 4);
    chk("ramp_frame_done", n_fd, 1);

    // Max located at each of the four window positions.
    fill_const(10);
    fr[0][0] = 200; fr[0][3] = 200; fr[3][0] = 200; fr[3][3] = 200;
    n_out = 0;
    send_frame(0, R * C);
    chk("maxpos_outputs", n_out, 4);

    // Ramp with random idle gaps.
    fill_ramp();
    n_out = 0; n_fd = 0;
    send_frame(3, R * C);
    chk("gap_outputs", n_out, 4);
    chk("gap_frame_done", n_fd, 1);

    // Partial frame, then asynchronous reset mid-cycle.
    send_frame(0, 6);
    din_valid = 1'b0;
    #2 rst = 1'b0;
    #1 outputs_cleared("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_dout = 0;
    n_out = 0; n_fd = 0;
    send_frame(0, R * C);
    chk("post_rst_outputs", n_out, 4);
    chk("post_rst_frame_done", n_fd, 1);

    // Back-to-back frames with no idle cycle between them.
    n_out = 0; n_fd = 0;
    fill_const(255);
    send_frame(0, R * C);
    fill_const(0);
    send_frame(0, R * C);
    chk("b2b_outputs", n_out, 8);
    chk("b2b_frame_done", n_fd, 2);

    // Random-content frames with random gaps.
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) fr[r][c] = $urandom_range(255, 0);
      send_frame(f % 4, R * C);
    end

    din_valid = 1'b0;
    step(1'b0, 0, 1'b0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
